// File: rtl/eth_tx_pkg.sv
// Shared Ethernet TX definitions: FSM encoding and
// framing / CRC-32 constants.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG,
    S_ABORT
  } state_e;

  localparam logic [7:0]  ETH_PREAMBLE   = 8'h55;
  localparam logic [7:0]  ETH_SFD        = 8'hD5;
  localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_POLY     = 32'h04C11DB7;
  // Bit-reversed form of CRC32_POLY for the LSB-first shifter
  localparam logic [31:0] CRC32_POLY_REF = 32'hEDB88320;

endpackage

// File: rtl/crc32_d8.sv
// Combinational Ethernet CRC-32 step over one byte,
// reflected, data consumed LSB first.
module crc32_d8
  import eth_tx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  // Eight serial shift/xor steps unrolled into one cycle
  always_comb begin
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC32_POLY_REF;
      else             c = c >> 1;
    end
    crc_out = c;
  end

endmodule

// File: rtl/phy_tx_frame_reader.sv
// Drains one PHY TX FIFO onto a byte-wide GMII/MII transmit
// port: preamble, SFD, data, pad, FCS, inter-frame gap.
module phy_tx_frame_reader
  import eth_tx_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_LEN      = 60,
  parameter int MAX_LEN      = 1514,
  parameter int IFG_LEN      = 12
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        tx_ce,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_del,
  input  logic        fifo_empty,
  output logic        fifo_rden,
  output logic [7:0]  txd,
  output logic        tx_en,
  output logic        tx_er,
  output logic        busy,
  output logic        frame_done,
  output logic        err_underrun,
  output logic [15:0] frame_cnt
);

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);
  localparam logic [7:0]  PRE_L = 8'(PREAMBLE_LEN);
  localparam logic [7:0]  IFG_L = 8'(IFG_LEN - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [10:0] len_q;
  logic [31:0] crc_q;
  logic [7:0]  txd_q;
  logic        tx_en_q;
  logic        tx_er_q;
  logic        done_q;
  logic        err_q;
  logic [15:0] fcnt_q;

  logic [7:0]  crc_din;
  logic [31:0] crc_d;
  logic [10:0] len_d;
  logic        in_data;

  // Pad bytes feed zeros into the CRC, data bytes feed the FIFO
  assign crc_din = (state_q == S_PAD) ? 8'h00 : fifo_dout;
  assign len_d   = len_q + 11'd1;
  assign in_data = (state_q == S_SFD) || (state_q == S_DATA);

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .d       (crc_din),
    .crc_out (crc_d)
  );

  // Pop on data ticks, or every clk while flushing an abort
  assign fifo_rden = ~fifo_empty &
                     ((in_data & tx_ce) | (state_q == S_ABORT));

  assign txd          = txd_q;
  assign tx_en        = tx_en_q;
  assign tx_er        = tx_er_q;
  assign busy         = (state_q != S_IDLE);
  assign frame_done   = done_q;
  assign err_underrun = err_q;
  assign frame_cnt    = fcnt_q;

  // Frame sequencer with registered wire-side outputs
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      crc_q   <= CRC32_INIT;
      txd_q   <= '0;
      tx_en_q <= 1'b0;
      tx_er_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == S_ABORT) begin
        tx_en_q <= 1'b0;
        tx_er_q <= 1'b0;
        if (!fifo_empty && fifo_del) begin
          state_q <= S_IFG;
          cnt_q   <= '0;
        end
      end else if (tx_ce) begin
        unique case (state_q)
          S_IDLE: begin
            crc_q   <= CRC32_INIT;
            len_q   <= '0;
            tx_er_q <= 1'b0;
            cnt_q   <= '0;
            if (!fifo_empty) begin
              txd_q   <= ETH_PREAMBLE;
              tx_en_q <= 1'b1;
              cnt_q   <= 8'd1;
              state_q <= S_PREAMBLE;
            end else begin
              txd_q   <= '0;
              tx_en_q <= 1'b0;
            end
          end
          S_PREAMBLE: begin
            if (cnt_q >= PRE_L) begin
              txd_q   <= ETH_SFD;
              state_q <= S_SFD;
            end else begin
              txd_q <= ETH_PREAMBLE;
              cnt_q <= cnt_q + 8'd1;
            end
          end
          // The tick leaving SFD already carries the first byte
          S_SFD, S_DATA: begin
            if (fifo_empty) begin
              txd_q   <= '0;
              tx_en_q <= 1'b1;
              tx_er_q <= 1'b1;
              err_q   <= 1'b1;
              state_q <= S_ABORT;
            end else begin
              txd_q <= fifo_dout;
              crc_q <= crc_d;
              len_q <= len_d;
              if (fifo_del) begin
                cnt_q   <= '0;
                state_q <= (len_d < MIN_L) ? S_PAD : S_FCS;
              end else if (len_d == MAX_L) begin
                tx_er_q <= 1'b1;
                err_q   <= 1'b1;
                state_q <= S_ABORT;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
          S_PAD: begin
            txd_q <= 8'h00;
            crc_q <= crc_d;
            len_q <= len_d;
            if (len_d >= MIN_L) begin
              cnt_q   <= '0;
              state_q <= S_FCS;
            end
          end
          S_FCS: begin
            txd_q <= ~crc_q[{cnt_q[1:0], 3'b000} +: 8];
            if (cnt_q[1:0] == 2'd3) begin
              done_q  <= 1'b1;
              fcnt_q  <= fcnt_q + 16'd1;
              cnt_q   <= '0;
              state_q <= S_IFG;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          S_IFG: begin
            txd_q   <= '0;
            tx_en_q <= 1'b0;
            tx_er_q <= 1'b0;
            if (cnt_q >= IFG_L) begin
              cnt_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phy_tx_frame_reader.sv
// Directed bench for phy_tx_frame_reader: framing, padding,
// FCS, underrun/oversize aborts, slow tx_ce, async reset.
module tb_phy_tx_frame_reader;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic tx_ce = 1'b1;
  int   ce_div = 1;
  int   ce_ph = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ce_ph = (ce_ph + 1) % ce_div;
    tx_ce = (ce_ph == 0);
  end

  // FIFO model for the default instance
  logic [8:0]  mem_b [0:4095];
  logic [11:0] rd_b, wr_b;
  logic [7:0]  dout_b;
  logic        del_b, empty_b, rden_b;
  assign dout_b  = mem_b[rd_b][7:0];
  assign del_b   = mem_b[rd_b][8];
  assign empty_b = (rd_b == wr_b);
  always @(posedge clk or posedge arst)
    if (arst) rd_b <= '0;
    else if (rden_b) rd_b <= rd_b + 12'd1;

  // FIFO model for the MIN_LEN=0 instance
  logic [8:0]  mem_a [0:15];
  logic [3:0]  rd_a, wr_a;
  logic [7:0]  dout_a;
  logic        del_a, empty_a, rden_a;
  assign dout_a  = mem_a[rd_a][7:0];
  assign del_a   = mem_a[rd_a][8];
  assign empty_a = (rd_a == wr_a);
  always @(posedge clk or posedge arst)
    if (arst) rd_a <= '0;
    else if (rden_a) rd_a <= rd_a + 4'd1;

  logic [7:0]  txd_b, txd_a;
  logic        en_b, er_b, busy_b, done_b, err_b;
  logic        en_a, er_a, busy_a, done_a, err_a;
  logic [15:0] fc_b, fc_a;

  phy_tx_frame_reader u_dut (
    .clk (clk), .arst (arst), .tx_ce (tx_ce),
    .fifo_dout (dout_b), .fifo_del (del_b),
    .fifo_empty (empty_b), .fifo_rden (rden_b),
    .txd (txd_b), .tx_en (en_b), .tx_er (er_b),
    .busy (busy_b), .frame_done (done_b),
    .err_underrun (err_b), .frame_cnt (fc_b)
  );

  phy_tx_frame_reader #(.MIN_LEN(0)) u_dut0 (
    .clk (clk), .arst (arst), .tx_ce (tx_ce),
    .fifo_dout (dout_a), .fifo_del (del_a),
    .fifo_empty (empty_a), .fifo_rden (rden_a),
    .txd (txd_a), .tx_en (en_a), .tx_er (er_a),
    .busy (busy_a), .frame_done (done_a),
    .err_underrun (err_a), .frame_cnt (fc_a)
  );

  typedef struct packed {
    logic       en;
    logic       er;
    logic       pd;
    logic [7:0] d;
  } rec_t;

  rec_t qb[$];
  rec_t qa[$];
  int   ndone, nerr, hold_viol, rden_viol, ndone_a;
  int   nvec = 0;
  int   nbad = 0;

  // Per-tick wire capture; non-tick edges must hold txd
  always begin
    logic ce_s, pd_s, rv_s;
    logic [7:0] dp;
    @(posedge clk);
    ce_s = tx_ce;
    pd_s = rden_b & del_b;
    rv_s = (rden_b & empty_b) | (rden_a & empty_a);
    dp   = txd_b;
    #1;
    if (!arst) begin
      if (ce_s) begin
        qb.push_back({en_b, er_b, pd_s, txd_b});
        qa.push_back({en_a, er_a, 1'b0, txd_a});
      end else if (txd_b !== dp) hold_viol++;
      if (done_b) ndone++;
      if (err_b) nerr++;
      if (done_a) ndone_a++;
      if (rv_s) rden_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    arst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wr_b = '0;
    wr_a = '0;
    qb.delete();
    qa.delete();
    ndone = 0; nerr = 0; ndone_a = 0;
    hold_viol = 0; rden_viol = 0;
    arst = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] v, input logic d);
    mem_b[wr_b] = {d, v};
    wr_b = wr_b + 12'd1;
  endtask

  function automatic int first_en(input int from);
    for (int i = from; i < qb.size(); i++)
      if (qb[i].en) return i;
    return -1;
  endfunction

  int f, bad, cnt, k, n;
  logic [7:0] exp1 [0:20];

  initial begin
    // ---- reset state
    do_reset();
    chk("rst txd", 32'(txd_b), 0);
    chk("rst tx_en", 32'(en_b), 0);
    chk("rst tx_er", 32'(er_b), 0);
    chk("rst rden", 32'(rden_b), 0);
    chk("rst busy", 32'(busy_b), 0);
    chk("rst frame_cnt", 32'(fc_b), 0);

    // ---- 1: "123456789", MIN_LEN=0, known FCS
    for (int i = 0; i < 9; i++) begin
      mem_a[wr_a] = {(i == 8), 8'(8'h31 + i)};
      wr_a = wr_a + 4'd1;
    end
    for (int i = 0; i < 7; i++) exp1[i] = 8'h55;
    exp1[7] = 8'hD5;
    for (int i = 0; i < 9; i++) exp1[8+i] = 8'(8'h31 + i);
    exp1[17] = 8'h26; exp1[18] = 8'h39;
    exp1[19] = 8'hF4; exp1[20] = 8'hCB;
    for (int i = 0; i < 200 && ndone_a < 1; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    f = -1;
    for (int i = 0; i < qa.size(); i++)
      if (f < 0 && qa[i].en) f = i;
    chk("t1 start", 32'(f >= 0), 1);
    for (int i = 0; i < 21; i++)
      chk($sformatf("t1 byte%0d", i), 32'(qa[f+i].d), 32'(exp1[i]));
    bad = 0;
    for (int i = 0; i < 21; i++)
      if (!qa[f+i].en || qa[f+i].er) bad++;
    chk("t1 en/er", bad, 0);
    cnt = 0;
    for (int i = 21; i < 33; i++) if (!qa[f+i].en) cnt++;
    chk("t1 ifg low", cnt, 12);
    chk("t1 done", ndone_a, 1);
    chk("t1 frame_cnt", 32'(fc_a), 1);

    // ---- 2: 16-byte frame padded to 60
    do_reset();
    for (int i = 0; i < 16; i++) push_b(8'(i + 1), i == 15);
    for (int i = 0; i < 300 && ndone < 1; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    f = first_en(0);
    chk("t2 start", 32'(f >= 0), 1);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (qb[f+i].d != ((i == 7) ? 8'hD5 : 8'h55)) bad++;
    chk("t2 preamble", bad, 0);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (qb[f+8+i].d != 8'(i + 1)) bad++;
    chk("t2 data", bad, 0);
    bad = 0;
    for (int i = 0; i < 44; i++)
      if (qb[f+24+i].d != 8'h00) bad++;
    chk("t2 pad", bad, 0);
    cnt = 0; bad = 0;
    for (int i = f; i < qb.size() && qb[i].en; i++) begin
      cnt++;
      if (qb[i].er) bad++;
    end
    chk("t2 en ticks", cnt, 72);
    chk("t2 tx_er", bad, 0);
    chk("t2 done", ndone, 1);
    chk("t2 frame_cnt", 32'(fc_b), 1);

    // ---- 3: underrun after byte 20 of 100
    do_reset();
    for (int i = 0; i < 20; i++) push_b(8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 200 && nerr < 1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    f = first_en(0);
    bad = 0;
    for (int i = 0; i < 20; i++)
      if (qb[f+8+i].d != 8'(8'h80 + i) || qb[f+8+i].er) bad++;
    chk("t3 data", bad, 0);
    chk("t3 b21 en", 32'(qb[f+28].en), 1);
    chk("t3 b21 er", 32'(qb[f+28].er), 1);
    chk("t3 b21 txd", 32'(qb[f+28].d), 0);
    chk("t3 after en", 32'(qb[f+29].en), 0);
    chk("t3 cnt held", 32'(fc_b), 0);
    for (int i = 20; i < 100; i++) push_b(8'(i), i == 99);
    for (int i = 0; i < 16; i++) push_b(8'(i), i == 15);
    for (int i = 0; i < 600 && ndone < 1; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    k = -1;
    for (int i = f + 29; i < qb.size(); i++)
      if (k < 0 && qb[i].pd) k = i;
    n = (k < 0) ? -1 : first_en(k);
    chk("t3 gap", n - k, 13);
    chk("t3 frame_cnt", 32'(fc_b), 1);
    chk("t3 err count", nerr, 1);
    chk("t3 drained", 32'(rd_b == wr_b), 1);

    // ---- 4: 1600-byte frame, oversize abort
    do_reset();
    for (int i = 0; i < 1600; i++) push_b(8'(i), i == 1599);
    for (int i = 0; i < 2000 && nerr < 1; i++) @(negedge clk);
    for (int i = 0; i < 300 && rd_b != wr_b; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    f = first_en(0);
    bad = 0;
    for (int i = 0; i < 1513; i++)
      if (qb[f+8+i].d != 8'(i) || qb[f+8+i].er || !qb[f+8+i].en)
        bad++;
    chk("t4 data", bad, 0);
    chk("t4 b1514 en", 32'(qb[f+1521].en), 1);
    chk("t4 b1514 er", 32'(qb[f+1521].er), 1);
    chk("t4 b1514 txd", 32'(qb[f+1521].d), 32'h0E9);
    chk("t4 after en", 32'(qb[f+1522].en), 0);
    chk("t4 err count", nerr, 1);
    chk("t4 done", ndone, 0);
    chk("t4 frame_cnt", 32'(fc_b), 0);
    chk("t4 drained", 32'(rd_b == wr_b), 1);

    // ---- 5: tx_ce every 4th clk, 3 back-to-back frames
    do_reset();
    ce_div = 4;
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 64; i++) push_b(8'(j * 64 + i), i == 63);
    for (int i = 0; i < 2000 && ndone < 3; i++) @(negedge clk);
    repeat (8) @(negedge clk);
    f = first_en(0);
    for (int j = 0; j < 3; j++) begin
      bad = 0;
      for (int i = 0; i < 64; i++)
        if (qb[f+8+i].d != 8'(j * 64 + i)) bad++;
      chk($sformatf("t5 f%0d data", j), bad, 0);
      cnt = 0;
      for (int i = f; i < qb.size() && qb[i].en; i++) cnt++;
      chk($sformatf("t5 f%0d len", j), cnt, 76);
      if (j < 2) begin
        n = first_en(f + cnt);
        chk($sformatf("t5 f%0d ifg", j), n - (f + cnt), 12);
        f = n;
      end
    end
    chk("t5 hold", hold_viol, 0);
    chk("t5 frame_cnt", 32'(fc_b), 3);
    chk("t5 drained", 32'(rd_b == wr_b), 1);
    chk("t5 rden empty", rden_viol, 0);
    ce_div = 1;

    // ---- 6: async reset during the second frame's FCS
    do_reset();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 16; i++) push_b(8'(i), i == 15);
    for (int i = 0; i < 300 && ndone < 1; i++) @(negedge clk);
    f = first_en(0);
    for (int i = 0; i < 300 && qb.size() < f + 154; i++) begin
      @(posedge clk);
      #2;
    end
    chk("t6 pre en", 32'(en_b), 1);
    chk("t6 pre cnt", 32'(fc_b), 1);
    arst = 1'b1;
    #1;
    chk("t6 tx_en", 32'(en_b), 0);
    chk("t6 tx_er", 32'(er_b), 0);
    chk("t6 txd", 32'(txd_b), 0);
    chk("t6 busy", 32'(busy_b), 0);
    chk("t6 frame_cnt", 32'(fc_b), 0);
    chk("t6 rden", 32'(rden_b), 0);
    @(negedge clk);
    arst = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
